// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the two-master register file arbiter.
// Holds active-low enable levels, FSM state codes, owner ids and width defaults.
package regfile_arb_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int ADDR_W_DFLT = 5;
  localparam int DATA_W_DFLT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  function automatic logic req_any(
    input logic r0_,
    input logic r1_
  );
    return (r0_ == ENABLE_) || (r1_ == ENABLE_);
  endfunction

endpackage

// File: rtl/regfile_arb_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// Ports: req0_/req1_ active-low requests, last = master served last, grant = winner.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic   req0_,
  input  logic   req1_,
  input  owner_t last,
  output owner_t grant
);

  logic both;
  logic only0;
  logic only1;

  assign both  = (req0_ == ENABLE_) && (req1_ == ENABLE_);
  assign only0 = (req0_ == ENABLE_) && (req1_ == DISABLE_);
  assign only1 = (req0_ == DISABLE_) && (req1_ == ENABLE_);

  always_comb begin
    grant = M0;
    unique case (1'b1)
      both:    grant = (last == M0) ? M1 : M0;
      only0:   grant = M0;
      only1:   grant = M1;
      default: grant = M0;
    endcase
  end

endmodule

// File: rtl/regfile_arb.sv
// Arbitrates two active-low req_/ack_ masters onto one register file port.
// Ports: clk, reset_; m0_*/m1_* master buses; rf_* register file bus; busy.
module regfile_arb
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              m0_req_,
  input  logic              m0_we_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack_,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req_,
  input  logic              m1_we_,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack_,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_,
  input  logic [DATA_W-1:0] rf_d_out,
  output logic              busy
);

  state_t state;
  owner_t last;
  owner_t owner;
  owner_t grant;

  logic              win_we_;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arb2 u_rr (
    .req0_ (m0_req_),
    .req1_ (m1_req_),
    .last  (last),
    .grant (grant)
  );

  always_comb begin
    win_we_   = m0_we_;
    win_addr  = m0_addr;
    win_wdata = m0_wdata;
    if (grant == M1) begin
      win_we_   = m1_we_;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

  // The rf_* registers double as the latched command: loaded on grant,
  // cleared when ACCESS ends, so the async reset drops rf_we_ at once.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= IDLE;
      last     <= M1;
      owner    <= M0;
      m0_ack_  <= DISABLE_;
      m1_ack_  <= DISABLE_;
      m0_rdata <= '0;
      m1_rdata <= '0;
      rf_we_   <= DISABLE_;
      rf_addr  <= '0;
      rf_d_in  <= '0;
      busy     <= 1'b0;
    end else begin
      m0_ack_ <= DISABLE_;
      m1_ack_ <= DISABLE_;
      unique case (state)
        IDLE: begin
          if (req_any(m0_req_, m1_req_)) begin
            owner   <= grant;
            rf_we_  <= win_we_;
            rf_addr <= win_addr;
            rf_d_in <= win_wdata;
            busy    <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // rf_d_out still shows the old word here, so a write
          // hands back the pre-write contents.
          if (owner == M0) begin
            m0_rdata <= rf_d_out;
            m0_ack_  <= ENABLE_;
          end else begin
            m1_rdata <= rf_d_out;
            m1_ack_  <= ENABLE_;
          end
          rf_we_  <= DISABLE_;
          rf_addr <= '0;
          rf_d_in <= '0;
          state   <= DONE;
        end
        DONE: begin
          last  <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arb.sv
// Scoreboard bench for regfile_arb with a behavioural register file.
// Directed masters push expected rdata/ack cycle; a negedge monitor checks.
module tb_regfile_arb;
  import regfile_arb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic          m0_req_ = 1'b1;
  logic          m0_we_ = 1'b1;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack_;
  logic [DW-1:0] m0_rdata;
  logic          m1_req_ = 1'b1;
  logic          m1_we_ = 1'b1;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack_;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d_in;
  logic          rf_we_;
  logic [DW-1:0] rf_d_out;
  logic          busy;

  always #5 clk = ~clk;

  regfile_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset_   (reset_),
    .m0_req_  (m0_req_),
    .m0_we_   (m0_we_),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_ack_  (m0_ack_),
    .m0_rdata (m0_rdata),
    .m1_req_  (m1_req_),
    .m1_we_   (m1_we_),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_ack_  (m1_ack_),
    .m1_rdata (m1_rdata),
    .rf_addr  (rf_addr),
    .rf_d_in  (rf_d_in),
    .rf_we_   (rf_we_),
    .rf_d_out (rf_d_out),
    .busy     (busy)
  );

  logic [DW-1:0] mem [1<<AW] = '{default: '0};

  always @(posedge clk) begin
    if (!rf_we_) mem[rf_addr] <= rf_d_in;
  end
  assign rf_d_out = mem[rf_addr];

  typedef struct {
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int we_cnt = 0;
  int busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_) begin
      if (!rf_we_) we_cnt++;
      if (busy) busy_cnt++;
      if (!m0_ack_) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL m0_spurious_ack: ack_ low at cycle %0d, want high", cyc);
        end else begin
          e0 = q0.pop_front();
          chk("m0_rdata", m0_rdata, e0.rdata);
          chk("m0_ack_cycle", cyc, e0.cyc);
        end
      end
      if (!m1_ack_) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL m1_spurious_ack: ack_ low at cycle %0d, want high", cyc);
        end else begin
          e1 = q1.pop_front();
          chk("m1_rdata", m1_rdata, e1.rdata);
          chk("m1_ack_cycle", cyc, e1.cyc);
        end
      end
    end
  end

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_ack_ : m1_ack_;
  endfunction

  // Issue one command and hold req_ across n acks, releasing at the
  // edge where the last ack_ is sampled low.
  task automatic drive(input int m, input logic wr_, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int n, input int pre);
    int t;
    repeat (pre) begin
      @(posedge clk);
      #1;
    end
    if (m == 0) begin
      m0_req_ = 1'b0; m0_we_ = wr_; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req_ = 1'b0; m1_we_ = wr_; m1_addr = a; m1_wdata = d;
    end
    for (int k = 0; k < n; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (ack_of(m) !== 1'b0 && t < 40);
      if (ack_of(m) !== 1'b0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL m%0d_ack_timeout: ack_ high for %0d cycles, want 0", m, t);
        break;
      end
      @(posedge clk);
    end
    #1;
    if (m == 0) m0_req_ = 1'b1;
    else m1_req_ = 1'b1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int c;
  int w0;
  int b0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_m0_ack_", 32'(m0_ack_), 32'd1);
    chk("rst_m1_ack_", 32'(m1_ack_), 32'd1);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_rf_we_", 32'(rf_we_), 32'd1);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_rf_d_in", rf_d_in, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset_ = 1'b1;
    @(posedge clk);
    #1;

    c = cyc;
    w0 = we_cnt;
    q0.push_back('{32'h0, c + 2});
    fork
      drive(0, 1'b0, 5'd3, 32'hDEADBEEF, 1, 0);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("s1_rf_addr", 32'(rf_addr), 32'd3);
        chk("s1_rf_d_in", rf_d_in, 32'hDEADBEEF);
        chk("s1_busy", 32'(busy), 32'd1);
      end
    join
    chk("s1_we_cycles", we_cnt - w0, 32'd1);
    chk("s1_idle_rf_addr", 32'(rf_addr), 32'd0);
    c = cyc;
    q0.push_back('{32'hDEADBEEF, c + 2});
    drive(0, 1'b1, 5'd3, 32'h0, 1, 0);

    do_reset();
    for (int r = 0; r < 2; r++) begin
      c = cyc;
      q0.push_back('{32'hDEADBEEF, c + 2});
      q1.push_back('{(r == 0) ? 32'h0 : 32'hDEADBEEF, c + 5});
      fork
        drive(0, 1'b1, 5'd3, 32'h0, 1, 0);
        drive(1, 1'b1, (r == 0) ? 5'd0 : 5'd3, 32'h0, 1, 0);
      join
    end

    c = cyc;
    q1.push_back('{32'h0, c + 2});
    q1.push_back('{32'h0, c + 8});
    q1.push_back('{32'h0, c + 11});
    q1.push_back('{32'h0, c + 14});
    q0.push_back('{32'hDEADBEEF, c + 5});
    fork
      drive(1, 1'b1, 5'd0, 32'h0, 4, 0);
      drive(0, 1'b1, 5'd3, 32'h0, 1, 1);
    join

    c = cyc;
    q0.push_back('{32'h0, c + 2});
    drive(0, 1'b0, 5'd7, 32'h55, 1, 0);
    c = cyc;
    q1.push_back('{32'h55, c + 2});
    drive(1, 1'b0, 5'd7, 32'h1, 1, 0);
    c = cyc;
    q0.push_back('{32'h1, c + 2});
    drive(0, 1'b1, 5'd7, 32'h0, 1, 0);

    m0_req_ = 1'b0;
    m0_we_ = 1'b0;
    m0_addr = 5'd2;
    m0_wdata = 32'hAA;
    @(posedge clk);
    #2;
    chk("s5_pre_rf_we_", 32'(rf_we_), 32'd0);
    reset_ = 1'b0;
    #1;
    chk("s5_rf_we_", 32'(rf_we_), 32'd1);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_state", 32'(dut.state), 32'(IDLE));
    m0_req_ = 1'b1;
    m0_we_ = 1'b1;
    @(negedge clk);
    chk("s5_m0_ack_", 32'(m0_ack_), 32'd1);
    @(posedge clk);
    #1;
    chk("s5_mem2", mem[2], 32'd0);
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    c = cyc;
    q0.push_back('{32'h0, c + 2});
    drive(0, 1'b1, 5'd2, 32'h0, 1, 0);

    b0 = busy_cnt;
    c = cyc;
    q0.push_back('{32'h1, c + 2});
    m0_req_ = 1'b0;
    m0_we_ = 1'b1;
    m0_addr = 5'd7;
    @(posedge clk);
    #1;
    m0_req_ = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("s6_busy_cycles", busy_cnt - b0, 32'd2);
    chk("s6_q0_left", q0.size(), 32'd0);

    chk("end_q0_left", q0.size(), 32'd0);
    chk("end_q1_left", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout want done");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_arb.md
REGFILE_ARB -- requirements
Module: regfile_arb

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 5, register file address width.
- DATA_W, 32, register file data width.

REQ-002 Ports SHALL be, one per line (clock and reset first):
- clk  in  1  clock; all state updates on posedge.
- reset_  in  1  reset, asynchronous, active-low.
- m0_req_  in  1  master 0 access request, active-low.
- m0_we_  in  1  master 0 write enable, active-low; high = read.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ack_  out  1  master 0 access complete, active-low, one-cycle pulse.
- m0_rdata  out  DATA_W  master 0 read data, valid while m0_ack_ low.
- m1_req_, m1_we_, m1_addr, m1_wdata, m1_ack_, m1_rdata: same as m0_*, for master 1.
- rf_addr  out  ADDR_W  register file address.
- rf_d_in  out  DATA_W  register file write data.
- rf_we_  out  1  register file write enable, active-low.
- rf_d_out  in  DATA_W  register file combinational read data.
- busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-004 In IDLE with no req_ low, the FSM SHALL stay in IDLE.
REQ-005 In IDLE with any req_ low, at the clock edge:
- select a winner per REQ-006;
- latch the winner's we_, addr and wdata, plus the owner id;
- go to ACCESS.
REQ-006 Arbitration SHALL be two-way round-robin:
- a sole requester wins;
- if both request, the master not served last wins.
REQ-007 In ACCESS, the block SHALL drive the latched addr, wdata and we_ onto the rf_* ports.
REQ-008 At the end of ACCESS, rf_d_out SHALL be captured into the owner's rdata register, and the FSM SHALL go to DONE.
REQ-009 A write SHALL return the pre-write contents of the addressed location on rdata (read-before-write).
REQ-010 In DONE:
- the owner's ack_ SHALL be low for exactly one cycle;
- last-served SHALL update to the owner;
- the FSM SHALL go to IDLE.
REQ-011 Latency SHALL be as follows. With req_ sampled low at edge N, ACCESS occupies cycle N..N+1, and ack_ is low in the cycle following edge N+1. Peak throughput SHALL be one access per 3 cycles.
REQ-012 Each requester SHALL hold req_ low and its command stable until it samples ack_ low, then release req_ at that same edge. A req_ still low in IDLE SHALL be treated as a new request.
REQ-013 If req_ is withdrawn after the command is latched, the access SHALL still complete and ack_ SHALL still be issued.
REQ-014 Command inputs SHALL be ignored outside IDLE. A request arriving in ACCESS or DONE SHALL wait for IDLE.
REQ-015 Outside ACCESS:
- rf_we_ SHALL be high;
- rf_addr and rf_d_in SHALL be 0.
REQ-016 The non-owner's ack_ SHALL stay high at all times.
REQ-017 Each rdata SHALL hold its last captured value until that master's next capture.

Reset
REQ-018 While reset_ is low, the block SHALL hold:
- state = IDLE;
- last-served = master 1, so master 0 has priority first;
- both ack_ = 1 and both rdata = 0;
- rf_we_ = 1, rf_addr = 0, rf_d_in = 0;
- busy = 0.
REQ-019 Reset asserted mid-ACCESS SHALL abort the access immediately:
- no write SHALL occur, because rf_we_ is forced high asynchronously;
- no ack_ SHALL be issued for the aborted access.

Structure
REQ-020 The shared header SHALL hold:
- ENABLE_ (0) and DISABLE_ (1);
- state encodings IDLE, ACCESS, DONE;
- the default ADDR_W and DATA_W values.
REQ-021 The round-robin selection SHALL be a sub-module rr_arb2, purely combinational, with inputs req0_, req1_ and last, and output grant.

Verification
REQ-022 The bench SHALL cover, one line each:
- Reset, m0 writes addr 3 = 0xDEADBEEF -> m0_ack_ low 2 cycles after request; rf_we_ low in exactly one cycle; m0 then reads addr 3 -> m0_rdata = 0xDEADBEEF.
- Both masters request reads in the same cycle after reset -> m0 served first, m1 acked 3 cycles after m0; next simultaneous request -> m0 served first again, since last = m1.
- m1 holds req_ continuously for 4 accesses while m0 requests once -> m0 is acked no later than the second grant.
- Write addr 7 = 0x1 over existing 0x55 -> rdata = 0x55 at ack; a subsequent read of addr 7 = 0x1.
- Assert reset_ during ACCESS of a write of 0xAA to addr 2 -> addr 2 unchanged, no ack_, state IDLE, busy = 0.
- m0 releases req_ during ACCESS -> m0_ack_ still pulses once; no second access occurs.
